dut_io_stream_pack: RTL and testbench



---
 rtl/dut_io_stream_pack_pkg.sv | 31 +++
 rtl/dut_io_stream_pack_word_ptr.sv | 32 +++
 rtl/dut_io_stream_pack.sv | 174 +++++++++++++++++
 tb/tb_dut_io_stream_pack.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_io_stream_pack_pkg.sv
// Shared definitions for the AXI-word <-> DUT-vector stream bridge:
// mode encodings, FSM state types and word-count helpers.
package dut_io_stream_pack_pkg;

  // Transfer modes shared by the input and output sides
  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  // Input side: gather words, then apply the vector to the DUT in one cycle
  typedef enum logic {
    IN_FILL   = 1'b0,
    IN_COMMIT = 1'b1
  } in_state_t;

  // Output side: wait for a capture, then present snapshot words
  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_DRAIN = 1'b1
  } out_state_t;

  // Number of words needed to hold a vector of the given width
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Pointer width for a word count; a single-word buffer still gets one bit
  function automatic int ptr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dut_io_stream_pack_word_ptr.sv
// Word pointer: counts 0..WORDS-1 with synchronous clear and wrap,
// and flags when it sits on the last word. Used for both wp and rp.
module dut_io_stream_pack_word_ptr
  import dut_io_stream_pack_pkg::*;
#(
  parameter int WORDS = 8,
  localparam int PW   = ptr_width(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic          last
);

  localparam logic [PW-1:0] LAST_IDX = PW'(WORDS - 1);

  assign last = (ptr == LAST_IDX);

  // Clear wins over increment so a restart never skips word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= last ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dut_io_stream_pack.sv
// Bridge between the 32-bit AXI-side word stream and arbitrary-width DUT
// vectors. Input words are staged and applied to the DUT atomically;
// DUT outputs are snapshotted and drained word by word.
module dut_io_stream_pack
  import dut_io_stream_pack_pkg::*;
#(
  parameter int IN_WIDTH   = 256,
  parameter int OUT_WIDTH  = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [31:0]           in_addr,
  input  logic                  in_commit,
  output logic [IN_WIDTH-1:0]   dut_in_vec,
  output logic                  dut_in_update,
  input  logic [OUT_WIDTH-1:0]  dut_out_vec,
  input  logic                  out_capture,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  out_mode,
  input  logic [31:0]           out_addr,
  output logic                  addr_err
);

  localparam int IN_WORDS  = ceil_div(IN_WIDTH, WORD_WIDTH);
  localparam int OUT_WORDS = ceil_div(OUT_WIDTH, WORD_WIDTH);
  localparam int IN_BITS   = IN_WORDS * WORD_WIDTH;
  localparam int OUT_BITS  = OUT_WORDS * WORD_WIDTH;
  localparam int IPW       = ptr_width(IN_WORDS);
  localparam int OPW       = ptr_width(OUT_WORDS);
  localparam logic [31:0] IN_LIMIT  = 32'(IN_WORDS);
  localparam logic [31:0] OUT_LIMIT = 32'(OUT_WORDS);

  // ---------------- input side ----------------
  in_state_t                            in_state;
  logic [IN_WORDS-1:0][WORD_WIDTH-1:0]  staging;
  logic [IN_WORDS-1:0][WORD_WIDTH-1:0]  staging_next;
  logic [IN_BITS-1:0]                   staging_next_flat;
  logic [IPW-1:0]                       wp;
  logic                                 wp_last;
  logic                                 in_hs;
  logic                                 in_seq;
  logic                                 in_addr_ok;
  logic                                 in_done;

  assign in_hs      = in_valid && in_ready;
  assign in_seq     = (in_mode == MODE_SEQ);
  assign in_addr_ok = (in_addr < IN_LIMIT);
  assign in_done    = (in_state == IN_FILL) &&
                      (in_commit || (in_hs && in_seq && wp_last));

  dut_io_stream_pack_word_ptr #(.WORDS(IN_WORDS)) u_wp (
    .clk   (clk),
    .reset (reset),
    .clear (in_state == IN_COMMIT),
    .inc   (in_hs && in_seq),
    .ptr   (wp),
    .last  (wp_last)
  );

  // Staging contents after this cycle's write, so a word written alongside
  // a commit lands in the committed vector
  always_comb begin
    staging_next = staging;
    if (in_hs) begin
      if (in_seq) begin
        staging_next[wp] = in_word;
      end else if (in_addr_ok) begin
        staging_next[in_addr[IPW-1:0]] = in_word;
      end
    end
  end

  assign staging_next_flat = staging_next;

  // Input FSM: vector and update pulse appear the cycle after the final word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state      <= IN_FILL;
      in_ready      <= 1'b1;
      dut_in_update <= 1'b0;
      dut_in_vec    <= '0;
      staging       <= '0;
    end else begin
      staging       <= staging_next;
      dut_in_update <= 1'b0;
      case (in_state)
        IN_FILL: begin
          if (in_done) begin
            in_state      <= IN_COMMIT;
            in_ready      <= 1'b0;
            dut_in_update <= 1'b1;
            dut_in_vec    <= staging_next_flat[IN_WIDTH-1:0];
          end
        end
        IN_COMMIT: begin
          in_state <= IN_FILL;
          in_ready <= 1'b1;
        end
        default: begin
          in_state <= IN_FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- output side ----------------
  out_state_t                           out_state;
  logic [OUT_WORDS-1:0][WORD_WIDTH-1:0] snapshot;
  logic [OPW-1:0]                       rp;
  logic                                 rp_last;
  logic                                 out_hs;
  logic                                 out_seq;
  logic                                 out_addr_ok;

  assign out_hs      = out_valid && out_ready && !out_capture;
  assign out_seq     = (out_mode == MODE_SEQ);
  assign out_addr_ok = (out_addr < OUT_LIMIT);

  dut_io_stream_pack_word_ptr #(.WORDS(OUT_WORDS)) u_rp (
    .clk   (clk),
    .reset (reset),
    .clear (out_capture),
    .inc   (out_hs && out_seq),
    .ptr   (rp),
    .last  (rp_last)
  );

  // Output FSM: a capture always restarts the drain from word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      out_valid <= 1'b0;
      snapshot  <= '0;
    end else if (out_capture) begin
      out_state <= OUT_DRAIN;
      out_valid <= 1'b1;
      snapshot  <= OUT_BITS'(dut_out_vec);
    end else if (out_state == OUT_DRAIN && out_hs && out_seq && rp_last) begin
      out_state <= OUT_IDLE;
      out_valid <= 1'b0;
    end
  end

  // Zero-latency word select from registered snapshot; out-of-range reads give 0
  always_comb begin
    out_word = '0;
    if (out_valid) begin
      if (out_seq) begin
        out_word = snapshot[rp];
      end else if (out_addr_ok) begin
        out_word = snapshot[out_addr[OPW-1:0]];
      end
    end
  end

  // Sticky flag for any completed handshake that addressed a missing word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if ((in_hs && !in_seq && !in_addr_ok) ||
                 (out_hs && !out_seq && !out_addr_ok)) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dut_io_stream_pack.sv
// Self-checking bench for dut_io_stream_pack with a 72-bit input vector
// and a 40-bit output vector (three input words, two output words).
module tb_dut_io_stream_pack;

  localparam int IN_WIDTH  = 72;
  localparam int OUT_WIDTH = 40;
  localparam int WW        = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WW-1:0]        in_word;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [31:0]          in_addr;
  logic                 in_commit;
  logic [IN_WIDTH-1:0]  dut_in_vec;
  logic                 dut_in_update;
  logic [OUT_WIDTH-1:0] dut_out_vec;
  logic                 out_capture;
  logic [WW-1:0]        out_word;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic [31:0]          out_addr;
  logic                 addr_err;

  dut_io_stream_pack #(
    .IN_WIDTH   (IN_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .WORD_WIDTH (WW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_addr       (in_addr),
    .in_commit     (in_commit),
    .dut_in_vec    (dut_in_vec),
    .dut_in_update (dut_in_update),
    .dut_out_vec   (dut_out_vec),
    .out_capture   (out_capture),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mode      (out_mode),
    .out_addr      (out_addr),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [71:0] exp_vec;
  } fill_vec_t;

  typedef struct {
    logic [39:0] vec;
  } out_vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] stg[3];
  int          m_wp = 0;
  fill_vec_t   fill_tab[3];
  out_vec_t    out_tab[3];

  // Compare one observed value against the bench's expectation
  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] model_vec();
    return {stg[2][7:0], stg[1], stg[0]};
  endfunction

  // Drive one input handshake (optionally with commit) and update the model
  task automatic apply_stimulus(input logic [31:0] w, input logic mode,
                                input logic [31:0] addr, input logic commit);
    check_output("in_ready_before_write", in_ready, 1'b1);
    in_word   = w;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_addr   = addr;
    in_commit = commit;
    if (mode == 1'b0) begin
      stg[m_wp] = w;
      m_wp = (m_wp == 2) ? 0 : m_wp + 1;
    end else if (addr < 3) begin
      stg[addr[1:0]] = w;
    end
    if (commit) m_wp = 0;
    tick();
    in_valid  = 1'b0;
    in_commit = 1'b0;
  endtask

  // Snapshot a DUT output vector and queue its words for the drain
  task automatic capture(input logic [39:0] vec);
    dut_out_vec = vec;
    out_capture = 1'b1;
    tick();
    out_capture = 1'b0;
    exp_q.delete();
    exp_q.push_back(vec[31:0]);
    exp_q.push_back({24'h0, vec[39:32]});
    check_output("capture_valid", out_valid, 1'b1);
    check_output("capture_word0", out_word, vec[31:0]);
  endtask

  // Sequential drain with out_ready toggling; bounded by a cycle budget
  task automatic drain(input string name);
    int budget = 0;
    out_mode = 1'b0;
    while (exp_q.size() > 0 && budget < 40) begin
      out_ready = budget[0];
      check_output({name, "_valid"}, out_valid, 1'b1);
      if (out_valid && out_ready) begin
        check_output({name, "_word"}, out_word, exp_q.pop_front());
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: %0d words left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check_output({name, "_valid_falls"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    in_word     = '0;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_addr     = '0;
    in_commit   = 1'b0;
    dut_out_vec = '0;
    out_capture = 1'b0;
    out_ready   = 1'b0;
    out_mode    = 1'b0;
    out_addr    = '0;
    for (int i = 0; i < 3; i++) stg[i] = '0;

    fill_tab[0] = '{32'h11111111, 32'h22222222, 32'hFFFFFF33, 72'h33_22222222_11111111};
    fill_tab[1] = '{32'hDEADBEEF, 32'h01234567, 32'h000000A5, 72'hA5_01234567_DEADBEEF};
    fill_tab[2].w0 = $urandom();
    fill_tab[2].w1 = $urandom();
    fill_tab[2].w2 = $urandom();
    fill_tab[2].exp_vec = {fill_tab[2].w2[7:0], fill_tab[2].w1, fill_tab[2].w0};

    out_tab[0].vec = 40'hAB_12345678;
    out_tab[1].vec = 40'h00_00000001;
    out_tab[2].vec = {$urandom_range(255, 0), $urandom()};

    #12;
    check_output("rst_dut_in_vec", dut_in_vec, '0);
    check_output("rst_update", dut_in_update, 1'b0);
    check_output("rst_in_ready", in_ready, 1'b1);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_word", out_word, '0);
    check_output("rst_addr_err", addr_err, 1'b0);
    reset = 1'b0;
    tick();

    // Sequential fills from the table
    for (int t = 0; t < 3; t++) begin
      apply_stimulus(fill_tab[t].w0, 1'b0, 32'd0, 1'b0);
      check_output("fill_no_update_w0", dut_in_update, 1'b0);
      apply_stimulus(fill_tab[t].w1, 1'b0, 32'd0, 1'b0);
      check_output("fill_no_update_w1", dut_in_update, 1'b0);
      apply_stimulus(fill_tab[t].w2, 1'b0, 32'd0, 1'b0);
      check_output("fill_update", dut_in_update, 1'b1);
      check_output("fill_vec", dut_in_vec, fill_tab[t].exp_vec);
      check_output("fill_ready_low", in_ready, 1'b0);
      tick();
      check_output("fill_ready_back", in_ready, 1'b1);
      check_output("fill_update_pulse", dut_in_update, 1'b0);
      check_output("fill_vec_hold", dut_in_vec, fill_tab[t].exp_vec);
    end

    // Addressed write, then a write with commit in the same cycle
    apply_stimulus(32'h0000000A, 1'b1, 32'd1, 1'b0);
    check_output("addr_no_update", dut_in_update, 1'b0);
    apply_stimulus(32'h0000000B, 1'b1, 32'd0, 1'b1);
    check_output("addr_commit_update", dut_in_update, 1'b1);
    check_output("addr_commit_vec", dut_in_vec, model_vec());
    tick();
    in_mode = 1'b0;

    // Table of captures drained sequentially with out_ready toggling
    for (int t = 0; t < 3; t++) begin
      capture(out_tab[t].vec);
      drain("drain_tab");
    end

    // Capture in the middle of a drain restarts from word 0
    capture(40'h55_CAFEF00D);
    out_ready = 1'b1;
    check_output("mid_word0", out_word, exp_q.pop_front());
    tick();
    check_output("mid_word1_pending", out_word, 32'h00000055);
    dut_out_vec = 40'h77_0BADBEEF;
    out_capture = 1'b1;
    tick();
    out_capture = 1'b0;
    out_ready   = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0BADBEEF);
    exp_q.push_back(32'h00000077);
    check_output("mid_restart_word", out_word, 32'h0BADBEEF);
    drain("drain_restart");

    // Addressed reads, including an out-of-range index
    capture(40'h9C_87654321);
    exp_q.delete();
    out_mode = 1'b1;
    out_addr = 32'd1;
    #1 check_output("addr_rd1", out_word, 32'h0000009C);
    out_addr = 32'd0;
    #1 check_output("addr_rd0", out_word, 32'h87654321);
    check_output("addr_err_clear", addr_err, 1'b0);
    out_addr  = 32'd5;
    out_ready = 1'b1;
    #1 check_output("addr_rd5_zero", out_word, '0);
    tick();
    out_ready = 1'b0;
    check_output("addr_err_set", addr_err, 1'b1);
    check_output("addr_stays_drain", out_valid, 1'b1);
    tick();
    tick();
    check_output("addr_err_sticky", addr_err, 1'b1);
    out_mode = 1'b0;
    out_addr = '0;

    // Reset in the middle of a fill aborts it without a commit
    apply_stimulus(32'hAAAA0001, 1'b0, 32'd0, 1'b0);
    apply_stimulus(32'hAAAA0002, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    #2;
    check_output("rst_mid_vec", dut_in_vec, '0);
    check_output("rst_mid_update", dut_in_update, 1'b0);
    check_output("rst_mid_err", addr_err, 1'b0);
    check_output("rst_mid_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) stg[i] = '0;
    m_wp = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("rst_after_update", dut_in_update, 1'b0);
      check_output("rst_after_vec", dut_in_vec, '0);
    end
    apply_stimulus(32'h13579BDF, 1'b0, 32'd0, 1'b0);
    apply_stimulus(32'h2468ACE0, 1'b0, 32'd0, 1'b0);
    apply_stimulus(32'h000000E7, 1'b0, 32'd0, 1'b0);
    check_output("post_rst_update", dut_in_update, 1'b1);
    check_output("post_rst_vec", dut_in_vec, 72'hE7_2468ACE0_13579BDF);
    tick();

    // Commit without a handshake, then an out-of-range input write
    apply_stimulus(32'h000000C3, 1'b1, 32'd2, 1'b0);
    check_output("c_only_no_update", dut_in_update, 1'b0);
    in_commit = 1'b1;
    tick();
    in_commit = 1'b0;
    m_wp = 0;
    check_output("c_only_update", dut_in_update, 1'b1);
    check_output("c_only_vec", dut_in_vec, model_vec());
    tick();
    check_output("oor_err_clear", addr_err, 1'b0);
    apply_stimulus(32'hFFFFFFFF, 1'b1, 32'd9, 1'b0);
    check_output("oor_in_err", addr_err, 1'b1);
    in_commit = 1'b1;
    tick();
    in_commit = 1'b0;
    check_output("oor_in_vec", dut_in_vec, model_vec());
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
